// File: rtl/alu_writeback.sv
// alu_writeback: retires one ALU result per transaction into A/X/Y/SP or a memory write, updating N/V/Z/C in P.
// Latency: register destinations are written on the accept edge with wb_done the next cycle; memory writes hold mem_we until mem_ack.
// Backpressure: wb_ready drops for the whole memory-write handshake, with no timeout; it is also low while reset is asserted.
//
// Ports:
//   clk, reset            - system clock; synchronous active-high reset
//   wb_valid / wb_ready   - transaction handshake (select, dest_sel, result, c_in, v_in, ea)
//   mem_we/addr/data/ack  - memory write request held stable until acknowledged
//   wb_done               - one-cycle completion pulse
//   reg_a..reg_p          - architectural register state
module alu_writeback #(
    parameter int          ADDR_W   = 16,
    parameter logic [7:0]  SP_RESET = 8'hFD,
    parameter logic [7:0]  P_RESET  = 8'h24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [4:0]        select,
    input  logic [2:0]        dest_sel,
    input  logic [7:0]        result,
    input  logic              c_in,
    input  logic              v_in,
    input  logic [ADDR_W-1:0] ea,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    input  logic              mem_ack,
    output logic              wb_done,
    output logic [7:0]        reg_a,
    output logic [7:0]        reg_x,
    output logic [7:0]        reg_y,
    output logic [7:0]        reg_sp,
    output logic [7:0]        reg_p
);

    typedef enum logic {IDLE, MEM_WR} state_t;

    // Destination codes share the encoding of dest_sel so pass ops can use it directly.
    localparam logic [2:0] D_A    = 3'd0;
    localparam logic [2:0] D_X    = 3'd1;
    localparam logic [2:0] D_Y    = 3'd2;
    localparam logic [2:0] D_SP   = 3'd3;
    localparam logic [2:0] D_M    = 3'd4;
    localparam logic [2:0] D_NONE = 3'd5;

    state_t     state;
    logic       accept;
    logic [2:0] dest;
    logic       pass_op;
    logic       nz_upd;
    logic       c_upd;
    logic       v_upd;

    assign wb_ready = (state == IDLE) && !reset;
    assign accept   = wb_valid && wb_ready;

    always_comb begin
        dest    = D_NONE;
        pass_op = 1'b0;
        c_upd   = 1'b0;
        v_upd   = 1'b0;
        case (select)
            5'd0, 5'd1, 5'd2:           dest = D_A;
            5'd3, 5'd4:                 begin dest = D_A; c_upd = 1'b1; v_upd = 1'b1; end
            5'd5, 5'd7, 5'd9, 5'd15:    begin dest = D_A; c_upd = 1'b1; end
            5'd6, 5'd8, 5'd10, 5'd16:   begin dest = D_M; c_upd = 1'b1; end
            5'd19, 5'd22:               dest = D_M;
            5'd17, 5'd20:               dest = D_X;
            5'd18, 5'd21:               dest = D_Y;
            5'd23, 5'd24, 5'd25:        begin dest = D_NONE; c_upd = 1'b1; end
            default:                    begin dest = dest_sel; pass_op = 1'b1; end // 11-14, 26-31
        endcase
        // Compares keep N/Z even though nothing is written; a pass op steered to
        // "no write" touches nothing, and loads into SP (TXS) leave flags alone.
        nz_upd = (dest != D_SP) && !(pass_op && (dest_sel > 3'd4));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            reg_a    <= 8'h00;
            reg_x    <= 8'h00;
            reg_y    <= 8'h00;
            reg_sp   <= SP_RESET;
            reg_p    <= P_RESET;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_data <= 8'h00;
            wb_done  <= 1'b0;
        end else begin
            wb_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (dest)
                            D_A:     reg_a  <= result;
                            D_X:     reg_x  <= result;
                            D_Y:     reg_y  <= result;
                            D_SP:    reg_sp <= result;
                            default: ;
                        endcase
                        if (nz_upd) begin
                            reg_p[7] <= result[7];
                            reg_p[1] <= (result == 8'h00);
                        end
                        if (c_upd) reg_p[0] <= c_in;
                        if (v_upd) reg_p[6] <= v_in;
                        if (dest == D_M) begin
                            mem_addr <= ea;
                            mem_data <= result;
                            mem_we   <= 1'b1;
                            state    <= MEM_WR;
                        end else begin
                            wb_done  <= 1'b1;
                        end
                    end
                end
                MEM_WR: begin
                    // Address and data stay latched; only the ack releases the FSM.
                    if (mem_ack) begin
                        mem_we  <= 1'b0;
                        wb_done <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_writeback.sv
module tb_alu_writeback;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  select;
    logic [2:0]  dest_sel;
    logic [7:0]  result;
    logic        c_in;
    logic        v_in;
    logic [15:0] ea;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data;
    logic        mem_ack;
    logic        wb_done;
    logic [7:0]  reg_a, reg_x, reg_y, reg_sp, reg_p;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_writeback #(.ADDR_W(16), .SP_RESET(8'hFD), .P_RESET(8'h24)) dut (
        .clk(clk), .reset(reset),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .select(select), .dest_sel(dest_sel), .result(result),
        .c_in(c_in), .v_in(v_in), .ea(ea),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ack(mem_ack),
        .wb_done(wb_done),
        .reg_a(reg_a), .reg_x(reg_x), .reg_y(reg_y), .reg_sp(reg_sp), .reg_p(reg_p)
    );

    // Advance one rising edge; outputs are then sampled 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] s, input logic [2:0] d, input logic [7:0] r,
                         input logic c, input logic v, input logic [15:0] a);
        wb_valid = 1'b1; select = s; dest_sel = d; result = r; c_in = c; v_in = v; ea = a;
    endtask

    task automatic test_reset();
        reset = 1'b1; wb_valid = 1'b0; mem_ack = 1'b0;
        select = '0; dest_sel = '0; result = '0; c_in = 0; v_in = 0; ea = '0;
        step(); step();
        total++; if (wb_ready !== 1'b0) begin bad++; $display("FAIL rst_ready_low got %b want 0", wb_ready); end
        reset = 1'b0;
        #1;
        total++; if (reg_sp !== 8'hFD) begin bad++; $display("FAIL rst_sp got %h want fd", reg_sp); end
        total++; if (reg_p !== 8'h24) begin bad++; $display("FAIL rst_p got %h want 24", reg_p); end
        total++; if ({reg_a, reg_x, reg_y} !== 24'h0) begin bad++; $display("FAIL rst_axy got %h want 000000", {reg_a, reg_x, reg_y}); end
        total++; if (wb_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got %b want 1", wb_ready); end
        total++; if ({mem_we, wb_done} !== 2'b00) begin bad++; $display("FAIL rst_we_done got %b want 00", {mem_we, wb_done}); end
        step();
        total++; if (wb_done !== 1'b0) begin bad++; $display("FAIL idle_done got %b want 0", wb_done); end
    endtask

    task automatic test_adc();
        drive(5'd3, 3'd0, 8'h80, 1'b0, 1'b1, 16'h0);
        step();
        wb_valid = 1'b0;
        total++; if (reg_a !== 8'h80) begin bad++; $display("FAIL adc_a got %h want 80", reg_a); end
        total++; if (reg_p !== 8'hE4) begin bad++; $display("FAIL adc_p got %h want e4", reg_p); end
        total++; if (wb_done !== 1'b1) begin bad++; $display("FAIL adc_done got %b want 1", wb_done); end
        step();
        total++; if (wb_done !== 1'b0) begin bad++; $display("FAIL adc_done_pulse got %b want 0", wb_done); end
    endtask

    task automatic test_mem_write();
        drive(5'd19, 3'd0, 8'h00, 1'b1, 1'b1, 16'h0200);
        step();
        // Offer a competing op while busy; it must not be taken.
        drive(5'd0, 3'd0, 8'h55, 1'b0, 1'b0, 16'hBEEF);
        total++; if (reg_p !== 8'h66) begin bad++; $display("FAIL incm_p got %h want 66", reg_p); end
        for (int i = 0; i < 4; i++) begin
            total++; if ({mem_we, mem_addr, mem_data} !== {1'b1, 16'h0200, 8'h00})
                begin bad++; $display("FAIL mw_hold[%0d] got %b/%h/%h want 1/0200/00", i, mem_we, mem_addr, mem_data); end
            total++; if ({wb_ready, wb_done} !== 2'b00)
                begin bad++; $display("FAIL mw_busy[%0d] got %b want 00", i, {wb_ready, wb_done}); end
            if (i == 3) begin mem_ack = 1'b1; wb_valid = 1'b0; end
            step();
        end
        mem_ack = 1'b0;
        total++; if ({mem_we, wb_done, wb_ready} !== 3'b011) begin bad++; $display("FAIL mw_ack got %b want 011", {mem_we, wb_done, wb_ready}); end
        total++; if (reg_a !== 8'h80) begin bad++; $display("FAIL mw_a_kept got %h want 80", reg_a); end
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        total++; if ({mem_we, wb_done} !== 2'b00) begin bad++; $display("FAIL idle_ack got %b want 00", {mem_we, wb_done}); end
    endtask

    task automatic test_pass_ops();
        drive(5'd14, 3'd1, 8'h90, 1'b0, 1'b0, 16'h0);
        step();
        total++; if ({reg_x, reg_p} !== 16'h90E4) begin bad++; $display("FAIL pass_x got %h want 90e4", {reg_x, reg_p}); end
        drive(5'd11, 3'd3, 8'h00, 1'b1, 1'b1, 16'h0);
        step();
        total++; if ({reg_sp, reg_p} !== 16'h00E4) begin bad++; $display("FAIL txs got %h want 00e4", {reg_sp, reg_p}); end
        drive(5'd11, 3'd0, 8'h00, 1'b0, 1'b0, 16'h0);
        step();
        total++; if ({reg_a, reg_p} !== 16'h0066) begin bad++; $display("FAIL pass_a got %h want 0066", {reg_a, reg_p}); end
        drive(5'd26, 3'd6, 8'h80, 1'b1, 1'b1, 16'h0);
        step();
        wb_valid = 1'b0;
        total++; if ({reg_a, reg_x, reg_y, reg_sp, reg_p, mem_we} !== {40'h0090000066, 1'b0})
            begin bad++; $display("FAIL pass_none got %h/%b want 0090000066/0", {reg_a, reg_x, reg_y, reg_sp, reg_p}, mem_we); end
        total++; if (wb_done !== 1'b1) begin bad++; $display("FAIL pass_none_done got %b want 1", wb_done); end
    endtask

    task automatic test_back_to_back();
        logic [4:0] sels [4] = '{5'd0, 5'd3, 5'd15, 5'd4};
        logic [7:0] res  [4] = '{8'h01, 8'hFF, 8'h00, 8'h7F};
        logic       cs   [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic       vs   [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [7:0] exp_p[4] = '{8'h65, 8'hA4, 8'h27, 8'h65};
        int pulses = 0;
        drive(5'd24, 3'd0, 8'h00, 1'b1, 1'b0, 16'h0);
        step();
        total++; if ({reg_x, reg_p, mem_we} !== {16'h9067, 1'b0}) begin bad++; $display("FAIL cpx got %h/%b want 9067/0", {reg_x, reg_p}, mem_we); end
        for (int k = 0; k < 4; k++) begin
            drive(sels[k], 3'd4, res[k], cs[k], vs[k], 16'h0);
            step();
            if (wb_done === 1'b1) pulses++;
            total++; if ({reg_a, reg_p} !== {res[k], exp_p[k]})
                begin bad++; $display("FAIL b2b[%0d] got %h want %h", k, {reg_a, reg_p}, {res[k], exp_p[k]}); end
        end
        wb_valid = 1'b0;
        step();
        if (wb_done === 1'b1) pulses++;
        total++; if (pulses !== 4) begin bad++; $display("FAIL b2b_pulses got %0d want 4", pulses); end
    endtask

    task automatic test_reset_in_mem_wr();
        int extra = 0;
        drive(5'd22, 3'd0, 8'h33, 1'b0, 1'b0, 16'h1234);
        step();
        wb_valid = 1'b0;
        total++; if ({mem_we, mem_addr, mem_data} !== {1'b1, 16'h1234, 8'h33}) begin bad++; $display("FAIL decm got %b/%h/%h want 1/1234/33", mem_we, mem_addr, mem_data); end
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        total++; if ({mem_we, mem_addr, mem_data, wb_done} !== 26'h0) begin bad++; $display("FAIL abort_mem got %b/%h/%h/%b want 0/0000/00/0", mem_we, mem_addr, mem_data, wb_done); end
        total++; if ({reg_a, reg_x, reg_y, reg_sp, reg_p} !== 40'h000000FD24) begin bad++; $display("FAIL abort_regs got %h want 000000fd24", {reg_a, reg_x, reg_y, reg_sp, reg_p}); end
        total++; if (wb_ready !== 1'b1) begin bad++; $display("FAIL abort_idle got %b want 1", wb_ready); end
        for (int i = 0; i < 3; i++) begin
            step();
            if (wb_done !== 1'b0 || mem_we !== 1'b0) extra++;
        end
        total++; if (extra !== 0) begin bad++; $display("FAIL abort_quiet got %0d want 0", extra); end
    endtask

    initial begin
        test_reset();
        test_adc();
        test_mem_write();
        test_pass_ops();
        test_back_to_back();
        test_reset_in_mem_wr();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_writeback.md
Name: alu_writeback

Overview:
- Destination end of the 6502 datapath's 5-bit compute-select path.
- Accepts one selected 8-bit ALU result per transaction together with the same select code, then:
  - writes the result into the architectural register (A, X, Y, SP), or
  - issues a handshaked memory write for read-modify-write ops,
  - and updates N/V/Z/C in P.
- Sits between the compute mux and the register/bus interface; owns A, X, Y, SP and P.

Parameters:
- ADDR_W, 16, memory address width
- SP_RESET, 8'hFD, stack pointer reset value
- P_RESET, 8'h24, status reset value (bit5=1, I=1, all others 0)

Ports:
- Clk  in  1  system clock, all state on rising edge
- Reset  in  1  synchronous, active-high
- wb_valid  in  1  result/select/flags presented
- wb_ready  out  1  block can accept this cycle
- select  in  5  op code: 0 ORA, 1 AND, 2 EOR, 3 ADC, 4 SBC, 5 LSR_A, 6 LSR_M, 7 ROL_A, 8 ROL_M, 9 ROR_A, 10 ROR_M, 11 PASS_X, 12 PASS_Y, 13 PASS_M, 14 PASS_A, 15 ASL_A, 16 ASL_M, 17 INC_X, 18 INC_Y, 19 INC_M, 20 DEC_X, 21 DEC_Y, 22 DEC_M, 23 CMP, 24 CPX, 25 CPY, 26-31 PASS_SP
- dest_sel  in  3  pass-op destination: 0 A, 1 X, 2 Y, 3 SP, 4 M; 5-7 no write
- result  in  8  selected ALU output
- c_in  in  1  ALU carry out
- v_in  in  1  ALU overflow
- ea  in  ADDR_W  effective address for M writes
- mem_we  out  1  memory write request
- mem_addr  out  ADDR_W  write address
- mem_data  out  8  write data
- mem_ack  in  1  memory write accepted
- wb_done  out  1  one-cycle completion pulse
- reg_a, reg_x, reg_y, reg_sp, reg_p  out  8 each  architectural state

Behaviour:
- Reset values, applied on any edge with Reset=1, overriding everything including a pending memory write:
  - reg_a = reg_x = reg_y = 0; reg_sp = SP_RESET; reg_p = P_RESET.
  - mem_we = 0, mem_addr = 0, mem_data = 0, wb_done = 0; state = IDLE.
- FSM states: IDLE, MEM_WR.
- wb_ready = (state == IDLE) && !Reset; combinational.
- Accept = wb_valid && wb_ready; sampled on the rising edge.
- Destination decode:
  - ops 0-5, 7, 9, 15 -> A
  - ops 6, 8, 10, 16, 19, 22 -> M
  - ops 17, 20 -> X
  - ops 18, 21 -> Y
  - ops 23-25 -> none (flags only)
  - ops 11-14 and 26-31 -> dest_sel
- Register destination, 1-cycle latency:
  - On the accept edge, write the register and update flags; wb_done = 1 in the following cycle.
  - State stays IDLE.
  - Back-to-back accepts are allowed every cycle.
- M destination:
  - On the accept edge: latch mem_addr = ea, mem_data = result; update flags; state -> MEM_WR; mem_we = 1 from the next cycle.
  - Hold mem_we, mem_addr and mem_data stable while in MEM_WR.
  - On the edge where mem_ack = 1 in MEM_WR: mem_we -> 0, state -> IDLE, wb_done = 1 for one cycle.
  - mem_ack in IDLE is ignored.
  - There is no timeout; the FSM waits indefinitely.
- Flags (P bits: 7 N, 6 V, 1 Z, 0 C); bits 5, 4, 3, 2 are never modified.
  - N = result[7], Z = (result == 0): updated for every accepted op except writes whose destination is SP, and except dest_sel 5-7.
  - C = c_in: ops 3, 4, 5-10, 15, 16, 23-25.
  - V = v_in: ops 3, 4 only.
- dest_sel is ignored for fixed-destination ops.
- Register and flag writes are single-edge: no partial update and no read-back hazard.
- Inputs other than wb_valid are don't-care when no accept occurs.
- Reset asserted while in MEM_WR abandons the write: mem_we is low in the cycle after the reset edge, and no wb_done is produced.

Test Plan:
1. Reset, then idle → reg_sp=8'hFD, reg_p=8'h24, reg_a=reg_x=reg_y=0, wb_ready=1, mem_we=0.
2. Accept select=3 (ADC), result=8'h80, c_in=0, v_in=1 → next cycle reg_a=8'h80; reg_p=8'hE4 (N=1, V=1, Z=0, C=0); wb_done pulses once.
3. Accept select=19 (INC_M), result=8'h00, ea=16'h0200; hold mem_ack=0 for 3 cycles, then 1 →
   - mem_we high for 4 cycles with mem_addr=16'h0200, mem_data=8'h00;
   - Z=1 from the accept edge;
   - wb_ready=0 throughout MEM_WR;
   - wb_done only after the ack edge.
4. Accept select=11, dest_sel=3, result=8'h00 (TXS) → reg_sp=8'h00, reg_p unchanged. Then select=11, dest_sel=0, result=8'h00 → reg_a=0, Z=1.
5. Accept select=24 (CPX), result=8'h00, c_in=1 → reg_x unchanged, Z=1, C=1, N=0, no mem_we. Then wb_valid held high for 4 consecutive cycles with distinct A ops → 4 accepts, 4 wb_done pulses.
6. Reset asserted on the second cycle of MEM_WR, with mem_ack never asserted → next cycle mem_we=0, state IDLE, no wb_done, all registers at reset values.
